// File: rtl/setpoint_pkg.sv
// Shared definitions for the setpoint key conditioner.
//   cmd_t      : 2-bit command code driven onto the temperature-set writedata bus
//   state_t    : press/repeat FSM state encoding
package setpoint_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_IDLE    = 2'b00;
  localparam cmd_t CMD_UP      = 2'b01;
  localparam cmd_t CMD_DOWN    = 2'b10;
  localparam cmd_t CMD_DEFAULT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    BOTH,
    WAIT_REL
  } state_t;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a counting debouncer for one key.
// The input is expected already polarity-normalised (1 = pressed), so the
// synchroniser clears to 0, the not-pressed level.
//   clk_clk     : system clock
//   reset_reset : synchronous active-high reset
//   raw_in      : asynchronous key level, 1 = pressed
//   stable_out  : debounced key level, 1 = pressed
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic raw_in,
  output logic stable_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchroniser stage boundary
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage boundary: any return to the accepted level restarts the
  // count, so only an uninterrupted run of DEBOUNCE_CYCLES flips the state.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign stable_out = stable;

endmodule

// File: rtl/setpoint_key_conditioner.sv
// Turns the raw UP/DOWN setpoint buttons into single-cycle command codes:
// first-press pulse, hold-to-auto-repeat, and a both-keys restore-default.
//   clk_clk                   : system clock
//   reset_reset               : synchronous active-high reset
//   key_up_raw, key_down_raw  : asynchronous raw buttons
//   temperature_set_writedata : 00 idle, 01 up, 10 down, 11 default (1-cycle pulses)
//   keys_stable               : debounced pressed state {down, up}
module setpoint_key_conditioner
  import setpoint_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 10000000,
  parameter int KEY_ACTIVE_LOW       = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       key_up_raw,
  input  logic       key_down_raw,
  output logic [1:0] temperature_set_writedata,
  output logic [1:0] keys_stable
);

  localparam int REPEAT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                              REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int TIMER_W    = $clog2(REPEAT_MAX + 1);

  // A period of 1 would produce back-to-back pulses; a debounce of 1 leaves
  // no counter at all.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_param_check
    $error("setpoint_key_conditioner: cycle parameters must be >= 2");
  end

  localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD_CYCLES - 1);

  logic               up_pressed;
  logic               dn_pressed;
  logic [1:0]         stable;
  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  cmd_t               cmd_n;
  cmd_t               cmd_p0;

  // Inverting ahead of the synchroniser lets it clear to 0 as "not pressed".
  assign up_pressed = (KEY_ACTIVE_LOW != 0) ? ~key_up_raw   : key_up_raw;
  assign dn_pressed = (KEY_ACTIVE_LOW != 0) ? ~key_down_raw : key_down_raw;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .raw_in     (up_pressed),
    .stable_out (stable[0])
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .raw_in     (dn_pressed),
    .stable_out (stable[1])
  );

  always_comb begin
    state_n = state;
    timer_n = timer;
    cmd_n   = CMD_IDLE;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        unique case (stable)
          2'b01: begin
            cmd_n   = CMD_UP;
            timer_n = DELAY_LOAD;
            state_n = HOLD_UP;
          end
          2'b10: begin
            cmd_n   = CMD_DOWN;
            timer_n = DELAY_LOAD;
            state_n = HOLD_DN;
          end
          2'b11: begin
            cmd_n   = CMD_DEFAULT;
            state_n = BOTH;
          end
          default: ;
        endcase
      end
      HOLD_UP, HOLD_DN: begin
        // Second key wins over a repeat falling due on the same edge.
        if (stable == 2'b11) begin
          cmd_n   = CMD_DEFAULT;
          state_n = BOTH;
        end else if (!stable[(state == HOLD_UP) ? 0 : 1]) begin
          timer_n = '0;
          state_n = IDLE;
        end else if (timer == '0) begin
          cmd_n   = (state == HOLD_UP) ? CMD_UP : CMD_DOWN;
          timer_n = PERIOD_LOAD;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      BOTH: begin
        if (stable != 2'b11) state_n = WAIT_REL;
      end
      WAIT_REL: begin
        if (stable == 2'b00) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control / output register stage boundary
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state  <= IDLE;
      timer  <= '0;
      cmd_p0 <= CMD_IDLE;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      cmd_p0 <= cmd_n;
    end
  end

  assign temperature_set_writedata = cmd_p0;
  assign keys_stable               = stable;

endmodule
